// File: rtl/sdram_boot_arbiter.sv
// Purpose: shares the zsdram command port between the ROM download stream and the motherboard bus.
// Latency: download byte committed 17-32 clk after dl_wr (one 16-clk mem_we pulse); CPU path is combinational.
// Backpressure: dl_wait stalls the host while a byte is pending; cpu_hold keeps the CPU off the port during download.
module sdram_boot_arbiter #(
    parameter logic [8:0]  PAGE0      = 9'h000,
    parameter logic [8:0]  PAGE1      = 9'h100,
    parameter logic [8:0]  PAGE2      = 9'h107,
    parameter int unsigned HOLD_SLOTS = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        cpu_hold,
    input  logic        cpu_r,
    input  logic        cpu_w,
    input  logic [22:0] cpu_a,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic [15:0] dl_count,
    output logic        dl_skip
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_HOLD
    } state_t;

    state_t      state;
    logic        dl_active_q;
    logic        ld_we;
    logic [22:0] ld_addr;
    logic [7:0]  ld_data;
    logic [31:0] hold_cnt;
    logic [31:0] hold_next;
    logic        dl_rise;
    logic        dl_fall;
    logic [10:0] dl_page;
    logic [8:0]  dl_bank;
    logic        dl_mapped;
    logic [7:0]  rd_mask;

    assign dl_rise   = dl_active & ~dl_active_q;
    assign dl_fall   = ~dl_active & dl_active_q;
    assign dl_page   = dl_addr[24:14];
    assign hold_next = hold_cnt + {31'd0, ce_ref};

    // Translate the 16 KB download page into its SDRAM bank; pages 3+ have no home.
    always_comb begin
        dl_bank   = PAGE0;
        dl_mapped = 1'b1;
        case (dl_page)
            11'd0:   dl_bank = PAGE0;
            11'd1:   dl_bank = PAGE1;
            11'd2:   dl_bank = PAGE2;
            default: dl_mapped = 1'b0;
        endcase
    end

    // Loader FSM: latch a byte, wait one full ce_ref slot to arm, write for one slot, then release.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            dl_active_q <= 1'b0;
            dl_wait     <= 1'b0;
            ld_we       <= 1'b0;
            ld_addr     <= '0;
            ld_data     <= '0;
            dl_count    <= '0;
            dl_skip     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            dl_active_q <= dl_active;
            // A new download starts fresh statistics; later assignments below may still set them.
            if (dl_rise) begin
                dl_count <= '0;
                dl_skip  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (dl_active && dl_wr) begin
                        if (dl_mapped) begin
                            ld_addr <= {dl_bank, dl_addr[13:0]};
                            ld_data <= dl_data;
                            dl_wait <= 1'b1;
                            state   <= S_ARM;
                        end else begin
                            dl_skip <= 1'b1;
                        end
                    end else if (dl_fall) begin
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_ARM: begin
                    if (ce_ref) begin
                        ld_we <= 1'b1;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (ce_ref) begin
                        ld_we   <= 1'b0;
                        dl_wait <= 1'b0;
                        if (dl_count != 16'hFFFF) begin
                            dl_count <= dl_count + 16'd1;
                        end
                        // A download that ended mid-write goes straight to the hold-off period.
                        if (dl_active) begin
                            state <= S_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (dl_rise) begin
                        state <= S_IDLE;
                    end else if (hold_next >= HOLD_SLOTS) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // dl_active_q bridges the single cycle between dl_active falling in IDLE and the FSM reaching HOLD.
    assign cpu_hold = dl_active | dl_active_q | (state != S_IDLE);

    // Port mux: loader owns the port while the CPU is held, otherwise the CPU passes straight through.
    always_comb begin
        if (cpu_hold) begin
            mem_oe   = 1'b0;
            mem_we   = ld_we;
            mem_addr = ld_addr;
            mem_din  = ld_data;
        end else begin
            mem_oe   = cpu_r;
            mem_we   = cpu_w;
            mem_addr = cpu_a;
            mem_din  = cpu_wdata;
        end
    end

    // Banks outside the low 4 MB and the two relocated ROM pages read as open bus (FF).
    always_comb begin
        rd_mask = 8'hFF;
        if (!cpu_a[22] || (cpu_a[22:14] == PAGE1) || (cpu_a[22:14] == PAGE2)) begin
            rd_mask = 8'h00;
        end
    end

    assign cpu_rdata = mem_dout | rd_mask;

endmodule

// File: tb/tb_sdram_boot_arbiter.sv
// Purpose: directed bench for sdram_boot_arbiter with a write scoreboard.
// Latency: checks 17-32 clk byte latency and 16-clk write pulses.
// Backpressure: exercises dl_wait stalls, protocol-violating writes and cpu_hold release timing.
module tb_sdram_boot_arbiter;

    logic        clk_sys   = 1'b0;
    logic        reset     = 1'b1;
    logic        ce_ref    = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr     = 1'b0;
    logic [24:0] dl_addr   = '0;
    logic [7:0]  dl_data   = '0;
    logic        dl_wait;
    logic        cpu_hold;
    logic        cpu_r     = 1'b0;
    logic        cpu_w     = 1'b0;
    logic [22:0] cpu_a     = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        mem_oe;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout  = '0;
    logic [15:0] dl_count;
    logic        dl_skip;

    int errors    = 0;
    int checks    = 0;
    int exp_count = 0;

    logic [30:0] exp_q[$];
    int          we_len = 0;
    logic [22:0] we_addr = '0;
    logic [7:0]  we_data = '0;

    sdram_boot_arbiter dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_ref    (ce_ref),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_wait   (dl_wait),
        .cpu_hold  (cpu_hold),
        .cpu_r     (cpu_r),
        .cpu_w     (cpu_w),
        .cpu_a     (cpu_a),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .dl_count  (dl_count),
        .dl_skip   (dl_skip)
    );

    always #5 clk_sys = ~clk_sys;

    // Slot strobe: one cycle high in every sixteen.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_ref = (ph == 15);
            ph = (ph + 1) % 16;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Loader write monitor: each completed mem_we pulse is matched against the scoreboard.
    always @(negedge clk_sys) begin
        logic [30:0] e;
        if (reset) begin
            we_len = 0;
        end else if (mem_we && cpu_hold) begin
            if (we_len == 0) begin
                we_addr = mem_addr;
                we_data = mem_din;
            end
            we_len++;
        end else if (we_len != 0) begin
            check("write_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(we_addr), 32'(e[30:8]));
                check("write_data", 32'(we_data), 32'(e[7:0]));
                check("write_len", 32'(we_len), 32'd16);
            end
            we_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_byte(input logic [24:0] a, input logic [7:0] d, input logic [22:0] ea, input bit push);
        tick();
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        if (push) exp_q.push_back({ea, d});
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic wait_we();
        int n;
        n = 0;
        while (!mem_we && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("we_seen", 32'(mem_we), 32'd1);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic [22:0] ea,
                             input bit mapped, input bit glitch);
        int n;
        start_byte(a, d, ea, mapped);
        n = 0;
        @(negedge clk_sys);
        while (dl_wait && n < 40) begin
            n++;
            if (glitch && n == 4) begin
                dl_wr   = 1'b1;
                dl_addr = 25'h00200;
                dl_data = 8'h22;
            end
            if (glitch && n == 5) dl_wr = 1'b0;
            @(negedge clk_sys);
        end
        if (mapped) begin
            checks++;
            assert (n >= 17 && n <= 32) else begin
                errors++;
                $error("FAIL wait_len observed=%0d expected=17..32", n);
            end
            if (exp_count < 65535) exp_count++;
            check("dl_count", 32'(dl_count), 32'(exp_count));
        end else begin
            check("skip_no_wait", 32'(n), 32'd0);
            check("dl_skip_set", 32'(dl_skip), 32'd1);
            repeat (40) @(negedge clk_sys);
            check("skip_count_unchanged", 32'(dl_count), 32'(exp_count));
        end
    endtask

    initial begin
        int n;
        int n_ce;
        int since;

        // Reset state
        cpu_a     = 23'h012345;
        cpu_wdata = 8'h99;
        mem_dout  = 8'h12;
        reset     = 1'b1;
        repeat (3) tick();
        @(negedge clk_sys);
        check("rst_dl_wait", 32'(dl_wait), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_oe", 32'(mem_oe), 32'd0);
        check("rst_dl_count", 32'(dl_count), 32'd0);
        check("rst_dl_skip", 32'(dl_skip), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h012345);
        check("rst_mem_din", 32'(mem_din), 32'h99);
        tick();
        reset = 1'b0;

        // Download start holds the CPU off the port
        dl_active = 1'b1;
        cpu_r     = 1'b1;
        tick();
        @(negedge clk_sys);
        check("dl_cpu_hold", 32'(cpu_hold), 32'd1);
        check("dl_oe_blocked", 32'(mem_oe), 32'd0);
        cpu_r = 1'b0;

        // Single byte, page map, unmapped page, protocol violation
        send_byte(25'h00005, 8'hA5, 23'h000005, 1'b1, 1'b0);
        send_byte(25'h04010, 8'h5A, 23'h400010, 1'b1, 1'b0);
        send_byte(25'h08003, 8'hC7, 23'h41C003, 1'b1, 1'b0);
        send_byte(25'h0C000, 8'hEE, 23'h000000, 1'b0, 1'b0);
        send_byte(25'h00100, 8'h11, 23'h000100, 1'b1, 1'b1);

        // Download ends during WRITE
        start_byte(25'h08000, 8'h3C, 23'h41C000, 1'b1);
        wait_we();
        dl_active = 1'b0;
        n = 0;
        while (dl_wait && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("end_wait_cleared", 32'(dl_wait), 32'd0);
        exp_count++;
        check("end_dl_count", 32'(dl_count), 32'(exp_count));
        check("end_hold_still", 32'(cpu_hold), 32'd1);
        n_ce  = 0;
        since = 0;
        n     = 0;
        while (n < 100) begin
            @(negedge clk_sys);
            n++;
            if (!cpu_hold) break;
            if (ce_ref) begin
                n_ce++;
                since = 0;
            end else begin
                since++;
            end
        end
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("hold_slots", 32'(n_ce), 32'd2);
        check("hold_fall_cycle", 32'(since), 32'd0);

        // CPU pass-through read of the freshly loaded AMSDOS bank
        tick();
        cpu_r    = 1'b1;
        cpu_a    = 23'h41C000;
        mem_dout = 8'h3C;
        @(negedge clk_sys);
        check("cpu_mem_oe", 32'(mem_oe), 32'd1);
        check("cpu_mem_addr", 32'(mem_addr), 32'h41C000);
        check("cpu_rdata_page2", 32'(cpu_rdata), 32'h3C);

        // Read mask
        tick();
        cpu_a    = 23'h404000;
        mem_dout = 8'h12;
        @(negedge clk_sys);
        check("mask_unmapped", 32'(cpu_rdata), 32'hFF);
        tick();
        cpu_a = 23'h012345;
        @(negedge clk_sys);
        check("mask_low", 32'(cpu_rdata), 32'h12);

        // CPU write pass-through
        tick();
        cpu_r     = 1'b0;
        cpu_w     = 1'b1;
        cpu_wdata = 8'h77;
        @(negedge clk_sys);
        check("cpu_mem_we", 32'(mem_we), 32'd1);
        check("cpu_mem_din", 32'(mem_din), 32'h77);
        check("cpu_w_no_oe", 32'(mem_oe), 32'd0);
        tick();
        cpu_w = 1'b0;

        // New download clears statistics; reset during WRITE aborts
        dl_active = 1'b1;
        tick();
        @(negedge clk_sys);
        check("rise_clears_skip", 32'(dl_skip), 32'd0);
        check("rise_clears_count", 32'(dl_count), 32'd0);
        exp_count = 0;
        start_byte(25'h00007, 8'h55, 23'h000007, 1'b0);
        wait_we();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_sys);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_dl_wait", 32'(dl_wait), 32'd0);
        check("abort_dl_count", 32'(dl_count), 32'd0);
        send_byte(25'h00009, 8'hC3, 23'h000009, 1'b1, 1'b0);

        // Finish the download and drain
        tick();
        dl_active = 1'b0;
        n = 0;
        while (cpu_hold && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("final_hold_released", 32'(cpu_hold), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
